// File: rtl/sh_rx.sv
// sh_rx: serial frame receiver.
// Samples s_in on bit_en strobes and recognises start / W data bits (LSB first) /
// [even parity] / stop framing. The received word is presented on a valid/ready slot.
// Optional feature macro: SH_RX_PARITY_EN (adds a PARITY state and perr checking).
module sh_rx #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         bit_en,
  input  logic         s_in,
  output logic [W-1:0] q,
  output logic         valid,
  input  logic         ready,
  output logic         ferr,
  output logic         ovf,
  output logic         perr
);

  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [W-1:0]    r_shreg;
  logic [W-1:0]    r_q;
  logic            r_valid;
  logic            r_ferr;
  logic            r_ovf;
`ifdef SH_RX_PARITY_EN
  logic            r_pbad;
  logic            r_perr;
`endif

  logic [W-1:0]    w_shift;
  logic            w_last;
  logic            w_slot_free;

  // Next shift-register value: new bit enters at the MSB, so bits land LSB-first
  assign w_shift     = W'({s_in, r_shreg} >> 1);
  assign w_last      = (r_cnt == CW'(W - 1));
  assign w_slot_free = !r_valid || ready;

  // Frame FSM, output slot and one-cycle error pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_shreg <= '0;
      r_q     <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovf   <= 1'b0;
`ifdef SH_RX_PARITY_EN
      r_pbad  <= 1'b0;
      r_perr  <= 1'b0;
`endif
    end else begin
      // Pulses last exactly one clock regardless of strobe spacing
      r_ferr <= 1'b0;
      r_ovf  <= 1'b0;
`ifdef SH_RX_PARITY_EN
      r_perr <= 1'b0;
`endif
      // Consumer handshake runs every edge; a load below overrides the clear
      if (r_valid && ready) begin
        r_valid <= 1'b0;
      end

      if (bit_en) begin
        case (r_state)
          IDLE: begin
            if (!s_in) begin
              r_state <= DATA;
              r_cnt   <= '0;
            end
          end
          DATA: begin
            r_shreg <= w_shift;
            r_cnt   <= r_cnt + CW'(1);
            if (w_last) begin
`ifdef SH_RX_PARITY_EN
              r_state <= PARITY;
`else
              r_state <= STOP;
`endif
            end
          end
`ifdef SH_RX_PARITY_EN
          PARITY: begin
            r_pbad  <= s_in ^ (^r_shreg);
            r_state <= STOP;
          end
`endif
          STOP: begin
            r_state <= IDLE;
            if (!s_in) begin
              r_ferr <= 1'b1;
`ifdef SH_RX_PARITY_EN
            end else if (r_pbad) begin
              r_perr <= 1'b1;
`endif
            end else if (w_slot_free) begin
              r_q     <= r_shreg;
              r_valid <= 1'b1;
            end else begin
              r_ovf <= 1'b1;
            end
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  assign q     = r_q;
  assign valid = r_valid;
  assign ferr  = r_ferr;
  assign ovf   = r_ovf;
`ifdef SH_RX_PARITY_EN
  assign perr  = r_perr;
`else
  assign perr  = 1'b0;
`endif

endmodule

// File: tb/tb_sh_rx.sv
// Self-checking bench for sh_rx (W=4). Parity cases run when SH_RX_PARITY_EN is defined.
module tb_sh_rx;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         bit_en;
  logic         s_in;
  logic [W-1:0] q;
  logic         valid;
  logic         ready;
  logic         ferr;
  logic         ovf;
  logic         perr;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] sb[$];
  logic [W-1:0] exp_w;

  sh_rx #(.W(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bit_en (bit_en),
    .s_in   (s_in),
    .q      (q),
    .valid  (valid),
    .ready  (ready),
    .ferr   (ferr),
    .ovf    (ovf),
    .perr   (perr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One serial bit preceded by `gap` non-strobe clocks carrying a misleading line value
  task automatic send_bit(input logic b, input int gap);
    for (int i = 0; i < gap; i++) begin
      bit_en = 1'b0;
      s_in   = ~b;
      tick();
      chk("gap_ferr", 32'(ferr), 32'd0);
      chk("gap_ovf",  32'(ovf),  32'd0);
      chk("gap_perr", 32'(perr), 32'd0);
    end
    bit_en = 1'b1;
    s_in   = b;
    tick();
    bit_en = 1'b0;
    s_in   = 1'b1;
  endtask

  // Start bit, data bits LSB first and (when built in) the even-parity bit
  task automatic send_body(input logic [W-1:0] d, input int gap, input logic pflip);
    send_bit(1'b0, gap);
    for (int i = 0; i < int'(W); i++) send_bit(d[i], gap);
`ifdef SH_RX_PARITY_EN
    send_bit((^d) ^ pflip, gap);
`else
    if (pflip) $display("note: parity flip ignored without parity");
`endif
  endtask

  task automatic pop_chk(input string tag);
    chk({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      exp_w = sb.pop_front();
      chk({tag, "_q"}, 32'(q), 32'(exp_w));
    end
    chk({tag, "_valid"}, 32'(valid), 32'd1);
  endtask

  task automatic consume(input string tag);
    ready  = 1'b1;
    bit_en = 1'b0;
    tick();
    ready  = 1'b0;
    chk({tag, "_cleared"}, 32'(valid), 32'd0);
  endtask

  initial begin
    rst_n  = 1'b0;
    bit_en = 1'b0;
    s_in   = 1'b1;
    ready  = 1'b0;
    tick();
    tick();
    chk("rst_q",     32'(q),     32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_ferr",  32'(ferr),  32'd0);
    chk("rst_ovf",   32'(ovf),   32'd0);
    chk("rst_perr",  32'(perr),  32'd0);
    rst_n = 1'b1;
    tick();

    // Basic frame 4'hA; nothing visible before the stop sample
    sb.push_back(4'hA);
    send_body(4'hA, 0, 1'b0);
    chk("a_before_stop", 32'(valid), 32'd0);
    send_bit(1'b1, 0);
    pop_chk("a");
    chk("a_no_err", 32'({ferr, ovf, perr}), 32'd0);
    tick();
    chk("a_hold_valid", 32'(valid), 32'd1);
    consume("a");
    chk("a_q_kept", 32'(q), 32'hA);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("ready_idle_noeffect", 32'(valid), 32'd0);

    // Framing error, then an immediately following frame 4'h5
    send_body(4'hA, 0, 1'b0);
    send_bit(1'b0, 0);
    chk("ferr_pulse", 32'(ferr),  32'd1);
    chk("ferr_valid", 32'(valid), 32'd0);
    sb.push_back(4'h5);
    send_body(4'h5, 0, 1'b0);
    chk("ferr_one_cycle", 32'(ferr), 32'd0);
    send_bit(1'b1, 0);
    pop_chk("f5");
    consume("f5");

    // Overrun: 4'h3 then 4'hC back-to-back with ready low
    sb.push_back(4'h3);
    send_body(4'h3, 0, 1'b0);
    send_bit(1'b1, 0);
    pop_chk("o3");
    send_body(4'hC, 0, 1'b0);
    send_bit(1'b1, 0);
    chk("ovf_pulse", 32'(ovf),   32'd1);
    chk("ovf_q_old", 32'(q),     32'h3);
    chk("ovf_valid", 32'(valid), 32'd1);
    tick();
    chk("ovf_one_cycle", 32'(ovf), 32'd0);
    consume("o3");

    // Same pair, second stop bit coincides with consumption of the first word
    sb.push_back(4'h3);
    send_body(4'h3, 0, 1'b0);
    send_bit(1'b1, 0);
    pop_chk("p3");
    sb.push_back(4'hC);
    send_body(4'hC, 0, 1'b0);
    ready = 1'b1;
    send_bit(1'b1, 0);
    ready = 1'b0;
    pop_chk("pC");
    chk("pC_no_ovf", 32'(ovf), 32'd0);
    consume("pC");

    // Strobe every third clock, frame 4'h9
    sb.push_back(4'h9);
    send_body(4'h9, 2, 1'b0);
    send_bit(1'b1, 2);
    pop_chk("s9");
    chk("s9_no_err", 32'({ferr, ovf, perr}), 32'd0);

    // Reset after the 2nd data bit while 4'h9 is still held
    send_bit(1'b0, 0);
    send_bit(1'b1, 0);
    send_bit(1'b1, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst_q",     32'(q),     32'd0);
    chk("mid_rst_valid", 32'(valid), 32'd0);
    sb.push_back(4'h6);
    send_body(4'h6, 0, 1'b0);
    chk("r6_before_stop", 32'(valid), 32'd0);
    send_bit(1'b1, 0);
    pop_chk("r6");
    consume("r6");

`ifdef SH_RX_PARITY_EN
    // Good parity accepted, bad parity dropped with perr while old word stays
    sb.push_back(4'h7);
    send_body(4'h7, 0, 1'b0);
    send_bit(1'b1, 0);
    pop_chk("par7");
    send_body(4'h7, 0, 1'b1);
    send_bit(1'b1, 0);
    chk("perr_pulse", 32'(perr),  32'd1);
    chk("perr_valid", 32'(valid), 32'd1);
    chk("perr_q",     32'(q),     32'h7);
    chk("perr_no_ovf", 32'(ovf),  32'd0);
    tick();
    chk("perr_one_cycle", 32'(perr), 32'd0);
    consume("par7");
    send_body(4'h2, 0, 1'b1);
    send_bit(1'b1, 0);
    chk("perr_empty_pulse", 32'(perr),  32'd1);
    chk("perr_empty_valid", 32'(valid), 32'd0);
`endif

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
